uart_tx: RTL

- 8-N/E/O-1/2 UART transmitter, LSB first; companion to the existing uart_rx receiver.
- Accepts bytes over a valid/ready handshake into a one-deep holding register.
- Serialises each byte onto rs232_tx at a fixed baud set by a cycle-count parameter.
- Back-to-back frames are sent with no idle gap when the holding register is refilled in time.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_tx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, baud constants for
// synthesis (50 MHz / 9600) and simulation, frame geometry helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int BAUD_END_SYN = 5207;
    localparam int BAUD_END_SIM = 56;
    localparam int DATA_BITS    = 8;
    localparam int BAUD_CNT_W   = 13;

    // Total sclk cycles from the first start-bit cycle to the last stop-bit cycle.
    function automatic int frame_cycles(input int baud_end, input int parity_en,
                                        input int stop_bits);
        return (1 + DATA_BITS + parity_en + stop_bits) * (baud_end + 1);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter shared by the UART transmitter and receiver.
//   sclk     : system clock
//   s_rst    : synchronous active-high reset
//   en       : count while high, held at 0 while low
//   bit_end  : last cycle of the current bit period
//   pre_end  : cycle before bit_end, for outputs that must be registered
//              yet coincide with bit_end
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int BAUD_END = BAUD_END_SYN
) (
    input  logic sclk,
    input  logic s_rst,
    input  logic en,
    output logic bit_end,
    output logic pre_end
);

    localparam logic [BAUD_CNT_W-1:0] END_VAL = BAUD_CNT_W'(BAUD_END);
    localparam logic [BAUD_CNT_W-1:0] PRE_VAL = BAUD_CNT_W'(BAUD_END - 1);

    logic [BAUD_CNT_W-1:0] baud_cnt;

    always_ff @(posedge sclk) begin
        if (s_rst || !en)
            baud_cnt <= '0;
        else if (baud_cnt == END_VAL)
            baud_cnt <= '0;
        else
            baud_cnt <= baud_cnt + 1'b1;
    end

    assign bit_end = en && (baud_cnt == END_VAL);
    assign pre_end = en && (baud_cnt == PRE_VAL);

endmodule

// File: rtl/uart_tx.sv
// 8-bit UART transmitter, LSB first, optional even/odd parity, 1 or 2 stop
// bits, one-deep holding register so frames can run back to back.
//   sclk     : system clock
//   s_rst    : synchronous active-high reset (aborts any frame in flight)
//   tx_data  : byte to send, taken when tx_valid && tx_ready
//   tx_valid : tx_data valid
//   tx_ready : holding register empty
//   rs232_tx : serial line, registered, idle high
//   tx_busy  : a frame is on the line
//   tx_done  : one-cycle pulse on the last cycle of the final stop bit
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_END   = BAUD_END_SYN,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       sclk,
    input  logic       s_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       rs232_tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    tx_state_e            state, state_nxt;
    logic [DATA_BITS-1:0] hold, shift, shift_nxt;
    logic                 hold_valid;
    logic [2:0]           bit_cnt, bit_cnt_nxt;
    logic                 load;
    logic                 line_nxt;
    logic                 bit_end, pre_end;

    uart_baud_tick #(.BAUD_END(BAUD_END)) u_baud (
        .sclk    (sclk),
        .s_rst   (s_rst),
        .en      (state != IDLE),
        .bit_end (bit_end),
        .pre_end (pre_end)
    );

    assign tx_ready = ~hold_valid;

    // Holding register. Unload (load) and accept never coincide: load
    // needs hold_valid, which forces tx_ready low.
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            hold       <= '0;
            hold_valid <= 1'b0;
        end else if (load) begin
            hold_valid <= 1'b0;
        end else if (tx_valid && tx_ready) begin
            hold       <= tx_data;
            hold_valid <= 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        load        = 1'b0;
        case (state)
            IDLE: begin
                if (hold_valid) begin
                    state_nxt = START;
                    load      = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt   = STOP;
                    bit_cnt_nxt = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt == LAST_STOP) begin
                        bit_cnt_nxt = '0;
                        // Refilled in time: chain straight into the next start bit.
                        if (hold_valid) begin
                            state_nxt = START;
                            load      = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        shift_nxt = load ? hold : shift;

        // Line level is decoded from the next state so rs232_tx itself is a flop.
        case (state_nxt)
            START:   line_nxt = 1'b0;
            DATA:    line_nxt = shift_nxt[bit_cnt_nxt];
            PARITY:  line_nxt = (^shift_nxt) ^ PARITY_ODD[0];
            default: line_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state    <= IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            rs232_tx <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_nxt;
            shift    <= shift_nxt;
            bit_cnt  <= bit_cnt_nxt;
            rs232_tx <= line_nxt;
            tx_busy  <= (state_nxt != IDLE);
            // Set one cycle early so the registered pulse lands on bit_end.
            tx_done  <= (state == STOP) && (bit_cnt == LAST_STOP) && pre_end;
        end
    end

endmodule
